// File: rtl/wd_mfm_pkg.sv
// Shared constants, FSM state encoding and the MFM byte encoder used by the
// write-side encoder.
package wd_mfm_pkg;

    localparam logic [15:0] MFM_SYNC_A1   = 16'h4489;
    localparam int          CLKS_PER_BYTE = 80;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_MARK     = 3'd3,
        ST_DATA     = 3'd4,
        ST_POST     = 3'd5
    } state_t;

    typedef struct packed {
        logic [15:0] cells;
        logic        prev;
    } mfm_word_t;

    // Each data bit becomes {clock, data}; the clock cell is set only between two zeros.
    function automatic mfm_word_t mfm_encode(input logic [7:0] data, input logic prev_bit);
        mfm_word_t r;
        logic      p;
        p       = prev_bit;
        r.cells = '0;
        for (int i = 7; i >= 0; i--) begin
            r.cells[2*i+1] = ~data[i] & ~p;
            r.cells[2*i]   = data[i];
            p              = data[i];
        end
        r.prev = p;
        return r;
    endfunction

endpackage

// File: rtl/wd_mfm_encoder_if.sv
// Host/drive-side signal bundle of the MFM write encoder.
interface wd_mfm_encoder_if;
    logic       start;
    logic [7:0] data_in;
    logic       tx_valid;
    logic       tx_ready;
    logic       mfm_out;
    logic       write_gate;
    logic       busy;
    logic       status_led;

    modport master (
        output start, data_in, tx_valid,
        input  tx_ready, mfm_out, write_gate, busy, status_led
    );

    modport slave (
        input  start, data_in, tx_valid,
        output tx_ready, mfm_out, write_gate, busy, status_led
    );
endinterface

// File: rtl/wd_mfm_cell_shifter.sv
// Cell timing, 16-cell shift register and write-pulse shaping; flags the last
// clock of each byte so the controller can reload the next cell word.
module wd_mfm_cell_shifter #(
    parameter int CELL_CLKS = 5,
    parameter int CELL_HI   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic        i_load,
    input  logic [15:0] i_word,
    output logic        o_boundary,
    output logic        o_mfm
);
    localparam int CW = $clog2(CELL_CLKS + 1);

    logic [CW-1:0] r_cell_cnt;
    logic [3:0]    r_cell_idx;
    logic [15:0]   r_shift;
    logic          w_cell_end;

    assign w_cell_end = (r_cell_cnt == CW'(CELL_CLKS - 1));
    assign o_boundary = i_run & w_cell_end & (r_cell_idx == 4'd15);
    assign o_mfm      = i_run & r_shift[15] & (r_cell_cnt < CW'(CELL_HI));

    // A load restarts cell 0 on the very next clock, so it overrides running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cell_cnt <= '0;
            r_cell_idx <= '0;
            r_shift    <= '0;
        end else if (i_load) begin
            r_cell_cnt <= '0;
            r_cell_idx <= '0;
            r_shift    <= i_word;
        end else if (!i_run) begin
            r_cell_cnt <= '0;
            r_cell_idx <= '0;
            r_shift    <= '0;
        end else if (w_cell_end) begin
            r_cell_cnt <= '0;
            r_cell_idx <= r_cell_idx + 4'd1;
            r_shift    <= {r_shift[14:0], 1'b0};
        end else begin
            r_cell_cnt <= r_cell_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/wd_mfm_encoder.sv
// MFM write encoder: preamble, A1 sync, mark, host payload and one postamble
// byte per start pulse, with write_gate covering the whole frame.
module wd_mfm_encoder
    import wd_mfm_pkg::*;
#(
    parameter int         CELL_CLKS    = 5,
    parameter int         CELL_HI      = 2,
    parameter int         PREAMBLE_LEN = 12,
    parameter logic [7:0] MARK_VAL     = 8'hFE
) (
    input  logic              clk_50,
    input  logic              reset,
    wd_mfm_encoder_if.slave   bus
);
    // state     | meaning
    // IDLE      | waiting for start, prev_bit held at 0
    // PREAMBLE  | sending PREAMBLE_LEN bytes of 0x00
    // SYNC      | sending A1 with missing clock (4489)
    // MARK      | sending MARK_VAL
    // DATA      | sending host payload bytes
    // POST      | sending one 0x00 postamble byte

    state_t      r_state;
    logic [7:0]  r_byte_cnt;
    logic        r_prev_bit;
    logic        r_write_gate;
    logic        r_busy;
    logic        r_status_led;

    logic        w_boundary;
    logic        w_mfm;
    logic        w_load;
    logic [15:0] w_word;
    logic        w_take;
    mfm_word_t   w_enc_data;
    mfm_word_t   w_enc_zero;
    mfm_word_t   w_enc_mark;
    mfm_word_t   w_enc_first;

    assign w_enc_data  = mfm_encode(bus.data_in, r_prev_bit);
    assign w_enc_zero  = mfm_encode(8'h00, r_prev_bit);
    assign w_enc_mark  = mfm_encode(MARK_VAL, r_prev_bit);
    assign w_enc_first = mfm_encode(8'h00, 1'b0);

    assign w_take = ((r_state == ST_MARK) || (r_state == ST_DATA)) & w_boundary & bus.tx_valid;

    always_comb begin
        w_load = 1'b0;
        w_word = w_enc_zero.cells;
        case (r_state)
            ST_IDLE: begin
                w_load = bus.start;
                w_word = w_enc_first.cells;
            end
            ST_PREAMBLE: begin
                w_load = w_boundary;
                w_word = (r_byte_cnt == 8'd0) ? MFM_SYNC_A1 : w_enc_zero.cells;
            end
            ST_SYNC: begin
                w_load = w_boundary;
                w_word = w_enc_mark.cells;
            end
            ST_MARK, ST_DATA: begin
                w_load = w_boundary;
                w_word = bus.tx_valid ? w_enc_data.cells : w_enc_zero.cells;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_prev_bit   <= 1'b0;
            r_write_gate <= 1'b0;
            r_busy       <= 1'b0;
            r_status_led <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_prev_bit <= 1'b0;
                    if (bus.start) begin
                        r_state      <= ST_PREAMBLE;
                        r_byte_cnt   <= 8'(PREAMBLE_LEN - 1);
                        r_write_gate <= 1'b1;
                        r_busy       <= 1'b1;
                        r_status_led <= 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_boundary) begin
                        if (r_byte_cnt == 8'd0) begin
                            r_state    <= ST_SYNC;
                            r_prev_bit <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt - 8'd1;
                            r_prev_bit <= w_enc_zero.prev;
                        end
                    end
                end
                ST_SYNC: begin
                    if (w_boundary) begin
                        r_state    <= ST_MARK;
                        r_prev_bit <= w_enc_mark.prev;
                    end
                end
                ST_MARK, ST_DATA: begin
                    if (w_boundary) begin
                        if (bus.tx_valid) begin
                            r_state    <= ST_DATA;
                            r_prev_bit <= w_enc_data.prev;
                        end else begin
                            r_state    <= ST_POST;
                            r_prev_bit <= w_enc_zero.prev;
                        end
                    end
                end
                ST_POST: begin
                    if (w_boundary) begin
                        r_state      <= ST_IDLE;
                        r_write_gate <= 1'b0;
                        r_busy       <= 1'b0;
                        r_status_led <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    wd_mfm_cell_shifter #(
        .CELL_CLKS (CELL_CLKS),
        .CELL_HI   (CELL_HI)
    ) u_shifter (
        .i_clk      (clk_50),
        .i_rst_n    (reset),
        .i_run      (r_busy),
        .i_load     (w_load),
        .i_word     (w_word),
        .o_boundary (w_boundary),
        .o_mfm      (w_mfm)
    );

    assign bus.tx_ready   = w_take;
    assign bus.mfm_out    = w_mfm;
    assign bus.write_gate = r_write_gate;
    assign bus.busy       = r_busy;
    assign bus.status_led = r_status_led;
endmodule

// File: tb/tb_wd_mfm_encoder.sv
// Directed bench for wd_mfm_encoder: rebuilds cell words from the pulse stream
// and compares frames against hand-encoded MFM words.
module tb_wd_mfm_encoder;
    typedef logic [15:0] word_q_t[$];
    typedef logic [7:0]  byte_q_t[$];

    logic clk_50;
    logic reset;
    int   n_checks;
    int   n_fail;

    wd_mfm_encoder_if bus ();

    wd_mfm_encoder #(
        .CELL_CLKS    (5),
        .CELL_HI      (2),
        .PREAMBLE_LEN (2),
        .MARK_VAL     (8'hFE)
    ) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Frame monitor: k counts clocks since write_gate rose; cell value taken at clock 0 of each cell.
    word_q_t mon_words;
    int      ready_k[$];
    int      mon_k;
    int      mon_cells;
    int      mon_pulse_err;
    int      mon_high;
    int      mon_stray;
    int      mon_double;
    logic    mon_cell;
    logic    mon_prev_ready;
    logic [15:0] mon_cur;

    task automatic clear_monitor();
        mon_words.delete();
        ready_k.delete();
        mon_k = 0; mon_cells = 0; mon_pulse_err = 0; mon_high = 0;
        mon_cur = '0; mon_cell = 1'b0;
    endtask

    always @(negedge clk_50) begin
        if (bus.tx_ready && mon_prev_ready) mon_double++;
        mon_prev_ready = bus.tx_ready;
        if (bus.write_gate) begin
            if (bus.mfm_out) mon_high++;
            case (mon_k % 5)
                0: mon_cell = bus.mfm_out;
                1: if (bus.mfm_out !== mon_cell) mon_pulse_err++;
                default: if (bus.mfm_out !== 1'b0) mon_pulse_err++;
            endcase
            if (mon_k % 5 == 4) begin
                mon_cur = {mon_cur[14:0], mon_cell};
                mon_cells++;
                if (mon_cells % 16 == 0) mon_words.push_back(mon_cur);
            end
            if (bus.tx_ready) ready_k.push_back(mon_k);
            mon_k++;
        end else if (bus.mfm_out || bus.tx_ready) begin
            mon_stray++;
        end
    end

    byte_q_t host_q;

    task automatic run_host(input bit poke_start);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            if (poke_start && c == 150) bus.start = 1'b1;
            if (poke_start && c == 152) bus.start = 1'b0;
            if (!bus.write_gate) begin
                done = 1'b1;
            end else if (bus.tx_ready) begin
                @(posedge clk_50);
                #1;
                void'(host_q.pop_front());
                if (host_q.size() > 0) bus.data_in = host_q[0];
                else begin bus.tx_valid = 1'b0; bus.data_in = 8'h00; end
                @(negedge clk_50);
            end else begin
                @(negedge clk_50);
            end
        end
        check_val("frame_end_timeout", 32'(done), 32'd1);
        bus.tx_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t payload, input bit poke_start, input bit immediate);
        clear_monitor();
        host_q = payload;
        if (!immediate) @(negedge clk_50);
        bus.tx_valid = (host_q.size() > 0);
        bus.data_in  = (host_q.size() > 0) ? host_q[0] : 8'h00;
        bus.start    = 1'b1;
        @(negedge clk_50);
        bus.start = 1'b0;
        check_val("gate_on", 32'(bus.write_gate), 32'd1);
        check_val("busy_on", 32'(bus.busy), 32'd1);
        check_val("led_on", 32'(bus.status_led), 32'd0);
        run_host(poke_start);
    endtask

    task automatic check_frame(input string name, input word_q_t exp, input int exp_ready0);
        int ones;
        ones = 0;
        check_val({name, "_clks"}, 32'(mon_k), 32'(exp.size() * 80));
        check_val({name, "_nwords"}, 32'(mon_words.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < mon_words.size(); i++) begin
            check_val($sformatf("%s_w%0d", name, i), 32'(mon_words[i]), 32'(exp[i]));
            ones += $countones(exp[i]);
        end
        check_val({name, "_pulse_shape"}, 32'(mon_pulse_err), 32'd0);
        check_val({name, "_high_clks"}, 32'(mon_high), 32'(2 * ones));
        check_val({name, "_nready"}, 32'(ready_k.size()), 32'(exp.size() - 5));
        for (int i = 0; i < ready_k.size(); i++)
            check_val($sformatf("%s_ready%0d_k", name, i), 32'(ready_k[i]), 32'(exp_ready0 + 80 * i));
        check_val({name, "_busy_off"}, 32'(bus.busy), 32'd0);
        check_val({name, "_led_off"}, 32'(bus.status_led), 32'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; mon_stray = 0; mon_double = 0; mon_prev_ready = 1'b0;
        clear_monitor();
        reset = 1'b0;
        bus.start = 1'b0; bus.data_in = 8'h00; bus.tx_valid = 1'b0;
        #25;
        check_val("rst_gate", 32'(bus.write_gate), 32'd0);
        check_val("rst_mfm", 32'(bus.mfm_out), 32'd0);
        check_val("rst_led", 32'(bus.status_led), 32'd1);
        check_val("rst_ready", 32'(bus.tx_ready), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk_50);
        reset = 1'b1;
        bus.tx_valid = 1'b1;
        repeat (200) @(negedge clk_50);
        bus.tx_valid = 1'b0;
        check_val("idle_no_frame", 32'(mon_k), 32'd0);
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Empty payload
        send_frame('{}, 1'b0, 1'b0);
        check_frame("empty", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'hAAAA}, 319);

        // 4E, 00
        send_frame('{8'h4E, 8'h00}, 1'b0, 1'b0);
        check_frame("p4e00", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'h9254,
                               16'hAAAA, 16'hAAAA}, 319);

        // FF, 00
        send_frame('{8'hFF, 8'h00}, 1'b0, 1'b0);
        check_frame("pff00", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'h5555,
                               16'h2AAA, 16'hAAAA}, 319);

        // start while busy, single byte then tx_valid drops; restart one cycle after busy clears
        send_frame('{8'h4E}, 1'b1, 1'b0);
        check_frame("busy_start", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'h9254,
                                    16'hAAAA}, 319);
        send_frame('{}, 1'b0, 1'b1);
        check_frame("restart", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'hAAAA}, 319);

        // Abort in DATA by reset between clock edges
        clear_monitor();
        @(negedge clk_50);
        bus.data_in = 8'hFF; bus.tx_valid = 1'b1; bus.start = 1'b1;
        @(negedge clk_50);
        bus.start = 1'b0;
        repeat (419) @(negedge clk_50);
        check_val("abort_in_frame", 32'(bus.write_gate), 32'd1);
        #3 reset = 1'b0;
        #1;
        check_val("abort_gate", 32'(bus.write_gate), 32'd0);
        check_val("abort_mfm", 32'(bus.mfm_out), 32'd0);
        check_val("abort_led", 32'(bus.status_led), 32'd1);
        check_val("abort_ready", 32'(bus.tx_ready), 32'd0);
        check_val("abort_busy", 32'(bus.busy), 32'd0);
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk_50);
        reset = 1'b1;
        repeat (100) @(negedge clk_50);
        check_val("abort_no_post", 32'(bus.write_gate), 32'd0);
        send_frame('{}, 1'b0, 1'b0);
        check_frame("after_abort", '{16'hAAAA, 16'hAAAA, 16'h4489, 16'h5554, 16'hAAAA}, 319);

        check_val("stray_activity", 32'(mon_stray), 32'd0);
        check_val("ready_back_to_back", 32'(mon_double), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
